// File: rtl/bmem_responder.sv
// bmem_responder: memory-side end of the bmem burst interface.
// Accepts 32-byte line reads and writes from one initiator. Each read line is
// returned as four 64-bit beats, beat 0 first, LATENCY cycles after the request
// is accepted. Reads are queued in order, up to QDEPTH outstanding.
//
// Optional feature macro: BMEM_RESP_ERRCHK_EN. When it is defined, bmem_err is
// a sticky protocol-error flag. When it is undefined, bmem_err is tied low.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   bmem_addr      request byte address; bits [4:0] are ignored
//   bmem_read      read request, held until it is received
//   bmem_write     write beat valid
//   bmem_wdata     write beat data
//   bmem_ready     a request or a beat can be taken this cycle
//   bmem_received  acknowledge: read accepted, or write beat 3 committed
//   bmem_raddr     line address of the returning beat, low 5 bits zero
//   bmem_rdata     read beat data
//   bmem_rvalid    read beat valid
//   bmem_err       protocol error flag
module bmem_responder #(
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MEM_LINES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic        bmem_received,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        bmem_err
);

  localparam int unsigned LW = $clog2(MEM_LINES);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned TW = $clog2(LATENCY);
  localparam logic [TW-1:0] T_INIT = TW'(LATENCY - 1);

  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_BEAT    = 1'b1;
  localparam logic [0:0] W_IDLE    = 1'b0;
  localparam logic [0:0] W_COLLECT = 1'b1;

  // Line storage; zero at time zero and never cleared by reset.
  logic [255:0] mem [MEM_LINES] = '{default: '0};

  // Read request queue: line address (bits 31:5) and countdown timer.
  logic [26:0]   q_addr [QDEPTH];
  logic [TW-1:0] q_tmr  [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, nxt_ptr;
  logic [CW-1:0] count;

  logic [0:0]    r_state, r_state_n;
  logic [1:0]    r_beat, r_beat_n;
  logic [0:0]    w_state, w_state_n;
  logic [1:0]    w_cnt, w_cnt_n;
  logic [LW-1:0] w_line;
  logic [191:0]  w_buf;

  logic          ready, read_acc, push, pop;
  logic          w_start, w_commit, w_gap;
  logic          head_due, next_due;
  logic [26:0]   head_addr;
  logic [255:0]  head_line;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bmem_addr[4:0];

  assign nxt_ptr   = rd_ptr + PW'(1);
  assign head_addr = q_addr[rd_ptr];
  assign head_line = mem[head_addr[LW-1:0]];

  // An entry is due once its timer reaches 0 at the coming edge. This puts
  // beat 0 exactly LATENCY cycles after the request is accepted.
  assign head_due = (count != '0) && (q_tmr[rd_ptr] <= TW'(1));
  assign next_due = (count >= CW'(2)) && (q_tmr[nxt_ptr] <= TW'(1));

  assign pop = (r_state == R_BEAT) && (r_beat == 2'd3);

  // A full queue that is popping this cycle can take a push into the freed slot.
  // Ready stays high while a write burst is being collected.
  assign ready = !rst && ((w_state == W_COLLECT) || (count != CW'(QDEPTH)) || pop);

  assign read_acc = bmem_read && ready && !bmem_write && (w_state == W_IDLE);
  assign push     = read_acc;
  assign w_start  = (w_state == W_IDLE) && bmem_write && ready;
  assign w_commit = !rst && (w_state == W_COLLECT) && bmem_write && (w_cnt == 2'd3);
  assign w_gap    = !rst && (w_state == W_COLLECT) && !bmem_write;

  // State registers and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_beat  <= '0;
      w_state <= W_IDLE;
      w_cnt   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      r_state <= r_state_n;
      r_beat  <= r_beat_n;
      w_state <= w_state_n;
      w_cnt   <= w_cnt_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= nxt_ptr;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Read return next state: four beats per line, chaining lines without a bubble.
  always_comb begin
    r_state_n = r_state;
    r_beat_n  = r_beat;
    case (r_state)
      R_IDLE: begin
        if (head_due) begin
          r_state_n = R_BEAT;
          r_beat_n  = 2'd0;
        end
      end
      R_BEAT: begin
        r_beat_n = r_beat + 2'd1;
        if (r_beat == 2'd3) r_state_n = next_due ? R_BEAT : R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Write collector next state: a gap in the beats abandons the burst.
  always_comb begin
    w_state_n = w_state;
    w_cnt_n   = w_cnt;
    case (w_state)
      W_IDLE: begin
        if (w_start) begin
          w_state_n = W_COLLECT;
          w_cnt_n   = 2'd1;
        end
      end
      W_COLLECT: begin
        if (!bmem_write || (w_cnt == 2'd3)) begin
          w_state_n = W_IDLE;
          w_cnt_n   = 2'd0;
        end else begin
          w_cnt_n = w_cnt + 2'd1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Queue payload: all timers count down; a push overrides its own slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      q_tmr[i] <= (q_tmr[i] != '0) ? q_tmr[i] - TW'(1) : '0;
    end
    if (push) begin
      q_addr[wr_ptr] <= bmem_addr[31:5];
      q_tmr[wr_ptr]  <= T_INIT;
    end
  end

  // Write collector data; the address is taken only with beat 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_line <= '0;
      w_buf  <= '0;
    end else if (w_start) begin
      w_line       <= bmem_addr[5 +: LW];
      w_buf[63:0]  <= bmem_wdata;
    end else if ((w_state == W_COLLECT) && bmem_write && (w_cnt != 2'd3)) begin
      w_buf[{w_cnt, 6'b0} +: 64] <= bmem_wdata;
    end
  end

  // Line commit on beat 3. A read beat in the same cycle still sees the old line.
  always_ff @(posedge clk) begin
    if (w_commit) mem[w_line] <= {bmem_wdata, w_buf};
  end

  assign bmem_ready    = ready;
  assign bmem_received = !rst && (read_acc || w_commit);
  assign bmem_rvalid   = !rst && (r_state == R_BEAT);
  assign bmem_raddr    = bmem_rvalid ? {head_addr, 5'b0} : '0;
  assign bmem_rdata    = bmem_rvalid ? head_line[{r_beat, 6'b0} +: 64] : '0;

`ifdef BMEM_RESP_ERRCHK_EN
  logic err_q, rd_wait_q;
  logic e_align, e_both, e_drop;

  assign e_align = !rst && (read_acc || w_start) && (bmem_addr[4:0] != 5'd0);
  assign e_both  = !rst && bmem_read && bmem_write;
  assign e_drop  = !rst && rd_wait_q && !bmem_read;

  // Sticky protocol error flag; rd_wait_q marks a read that is still unacknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      rd_wait_q <= 1'b0;
    end else begin
      rd_wait_q <= bmem_read && !read_acc;
      if (e_align || e_both || w_gap || e_drop) err_q <= 1'b1;
      if (e_align) $error("bmem_responder: misaligned address %h", bmem_addr);
      if (e_both)  $error("bmem_responder: read and write asserted together");
      if (w_gap)   $error("bmem_responder: write burst gap");
      if (e_drop)  $error("bmem_responder: read dropped before received");
    end
  end

  assign bmem_err = err_q && !rst;
`else
  assign bmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_responder.sv
// Self-checking bench for bmem_responder. A line-array memory model and a beat
// schedule (max(accept+LATENCY, previous line end+1)) predict every returned
// beat, including the cycle it appears on.
module tb_bmem_responder;
  localparam int unsigned L  = 8;
  localparam int unsigned QD = 4;
  localparam int unsigned ML = 1024;
  localparam int unsigned LW = $clog2(ML);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [63:0] wdata = '0;
  logic        bmem_ready, bmem_received, bmem_rvalid, bmem_err;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;

  bmem_responder #(.LATENCY(L), .QDEPTH(QD), .MEM_LINES(ML)) dut (
    .clk(clk), .rst(rst), .bmem_addr(addr), .bmem_read(rd), .bmem_write(wr),
    .bmem_wdata(wdata), .bmem_ready(bmem_ready), .bmem_received(bmem_received),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .bmem_err(bmem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] a; logic [63:0] d; } beat_t;
  beat_t obs_q[$];
  beat_t exp_q[$];

  always @(negedge clk) if (bmem_rvalid) obs_q.push_back('{cyc, bmem_raddr, bmem_rdata});

  logic [255:0] model [ML];
  logic [31:0]  req_q [$];
  int tests = 0;
  int fails = 0;
  int last_end = -1;
`ifdef BMEM_RESP_ERRCHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Schedule the four beats of an accepted read.
  task automatic expect_read(input int acc, input logic [31:0] a);
    int s;
    logic [255:0] ln;
    s  = acc + int'(L);
    if (s <= last_end) s = last_end + 1;
    ln = model[a[5 +: LW]];
    for (int k = 0; k < 4; k++) exp_q.push_back('{s + k, {a[31:5], 5'b0}, ln[64*k +: 64]});
    last_end = s + 3;
  endtask

  // Issue every address in req_q with bmem_read held high throughout.
  task automatic rd_burst(output int stalls);
    int n;
    stalls = 0;
    for (int i = 0; i < req_q.size(); i++) begin
      rd = 1'b1;
      addr = req_q[i];
      n = 0;
      @(negedge clk);
      while (!bmem_received && n < 50) begin
        stalls++;
        n++;
        tick();
        @(negedge clk);
      end
      chk($sformatf("rd_accept%0d", i), 64'(bmem_received), 64'(1));
      if (bmem_received) expect_read(cyc, req_q[i]);
      tick();
    end
    rd = 1'b0;
    req_q.delete();
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [255:0] line);
    int n;
    n = 0;
    wr = 1'b1;
    addr = a;
    wdata = line[63:0];
    @(negedge clk);
    while (!bmem_ready && n < 50) begin
      n++;
      tick();
      @(negedge clk);
    end
    chk("wr_ready", 64'(bmem_ready), 64'(1));
    chk("wr_rcv_b0", 64'(bmem_received), 64'(0));
    for (int k = 1; k < 4; k++) begin
      tick();
      wdata = line[64*k +: 64];
      addr = ~a & 32'hFFFF_FFE0;
      @(negedge clk);
      chk($sformatf("wr_rcv_b%0d", k), 64'(bmem_received), 64'(k == 3));
    end
    tick();
    wr = 1'b0;
    addr = '0;
    model[a[5 +: LW]] = line;
  endtask

  task automatic drain_cmp(input string tag);
    int n;
    int m;
    n = 0;
    while (cyc <= last_end + 2 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 64'(n < 400), 64'(1));
    chk({tag, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i),  64'(obs_q[i].c), 64'(exp_q[i].c));
      chk($sformatf("%s_addr%0d", tag, i), 64'(obs_q[i].a), 64'(exp_q[i].a));
      chk($sformatf("%s_data%0d", tag, i), obs_q[i].d, exp_q[i].d);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 64'(bmem_ready), 64'(0));
    chk({tag, "_rcv"},   64'(bmem_received), 64'(0));
    chk({tag, "_rvalid"}, 64'(bmem_rvalid), 64'(0));
    chk({tag, "_raddr"}, 64'(bmem_raddr), 64'(0));
    chk({tag, "_rdata"}, bmem_rdata, 64'(0));
    chk({tag, "_err"},   64'(bmem_err), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int b3;
    logic [255:0] ln;
    logic [31:0] a;
    for (int i = 0; i < int'(ML); i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk_outputs_zero("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bmem_ready), 64'(1));
    tick();

    // Preload line 3 and read it back at the fixed latency
    wr_line(32'h0000_0060, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    req_q.push_back(32'h0000_0060);
    rd_burst(stalls);
    drain_cmp("line3");

    // Write line 4 and read it back
    wr_line(32'h0000_0080, {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                            64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});
    req_q.push_back(32'h0000_0080);
    rd_burst(stalls);
    drain_cmp("line4");

    // Five back-to-back reads into a four-deep queue
    for (int i = 0; i < 5; i++) req_q.push_back(32'h0000_0060 + 32'(i % 2) * 32'h20);
    rd_burst(stalls);
    chk("qfull_stalls", 64'(stalls), 64'(7));
    drain_cmp("five");

    // Address wrap modulo MEM_LINES keeps the full address on raddr
    req_q.push_back(32'h0000_8060);
    rd_burst(stalls);
    drain_cmp("wrap");

    chk("err_clean", 64'(bmem_err), 64'(0));

    // Read and write together: write wins, read accepted after write beat 3
    ln = rnd_line();
    rd = 1'b1;
    wr = 1'b1;
    addr = 32'h0000_00A0;
    wdata = ln[63:0];
    @(negedge clk);
    chk("rw_rcv_b0", 64'(bmem_received), 64'(0));
    b3 = 0;
    for (int k = 1; k < 4; k++) begin
      tick();
      wdata = ln[64*k +: 64];
      addr = 32'h0000_0060;
      @(negedge clk);
      chk($sformatf("rw_rcv_b%0d", k), 64'(bmem_received), 64'(k == 3));
      b3 = cyc;
    end
    model[5] = ln;
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("rw_rd_acc", 64'(bmem_received), 64'(1));
    chk("rw_acc_cycle", 64'(cyc), 64'(b3 + 1));
    if (bmem_received) expect_read(cyc, 32'h0000_0060);
    tick();
    rd = 1'b0;
    chk("rw_err", 64'(bmem_err), 64'(ERR_ON));
    req_q.push_back(32'h0000_00A0);
    rd_burst(stalls);
    drain_cmp("rw");

    // Gap in a write burst: nothing is committed
    wr = 1'b1;
    addr = 32'h0000_0060;
    wdata = 64'hDEAD_BEEF_0000_0000;
    tick();
    wdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("gap_rcv", 64'(bmem_received), 64'(0));
    tick();
    req_q.push_back(32'h0000_0060);
    rd_burst(stalls);
    drain_cmp("gap");

    // Reset during write beat 2: no commit, outputs cleared
    wr = 1'b1;
    addr = 32'h0000_0060;
    wdata = 64'hFEED_0000_0000_0000;
    tick();
    wdata = 64'hFEED_0000_0000_0001;
    tick();
    wdata = 64'hFEED_0000_0000_0002;
    rst = 1'b1;
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(bmem_ready), 64'(1));
    tick();
    req_q.push_back(32'h0000_0060);
    rd_burst(stalls);
    drain_cmp("midrst");

    // Randomized write batches followed by pipelined read batches
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        a = $urandom();
        a[14:5] = 10'($urandom_range(0, 7));
        a[4:0] = '0;
        wr_line(a, rnd_line());
      end
      for (int r = 0; r < int'($urandom_range(1, 6)); r++) begin
        a = $urandom();
        a[14:5] = 10'($urandom_range(0, 7));
        a[4:0] = '0;
        req_q.push_back(a);
      end
      rd_burst(stalls);
      drain_cmp($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
